// File: rtl/mtm_alu_serializer.sv
// Transmit side of the MTM ALU serial link: shifts a 32-bit result plus a flags/CRC
// control byte, or a single error control byte, onto dout as 11-bit frames.
module mtm_alu_serializer #(
  parameter int unsigned GAP_BITS = 0,
  parameter logic [2:0]  CRC_INIT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [31:0] C_in,
  input  logic [3:0]  FLAGS_in,
  input  logic        err_valid,
  input  logic [7:0]  err_frame_in,
  output logic        dout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    TYPE  = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [2:0] GAP_LOAD = (GAP_BITS > 0) ? 3'(GAP_BITS - 1) : '0;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [2:0]  gap_cnt, gap_n;
  logic [2:0]  frame_cnt, frame_n;
  logic        is_err;
  logic [31:0] c_reg;
  logic [3:0]  flags_reg;
  logic [7:0]  err_reg;
  logic        accept;
  logic        dout_n;
  logic        last_frame;
  logic [2:0]  crc;
  logic [7:0]  cur_byte;

  // CRC-3, x^3+x+1, MSB first, no final XOR
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] r;
    logic       fb;
    r = CRC_INIT;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = r[2] ^ msg[36 - i];
      r  = {r[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return r;
  endfunction

  assign crc        = crc3({c_reg, 1'b0, flags_reg});
  assign last_frame = is_err || (frame_cnt == 3'd4);

  always_comb begin
    cur_byte = err_reg;
    if (!is_err) begin
      case (frame_cnt)
        3'd0:    cur_byte = c_reg[31:24];
        3'd1:    cur_byte = c_reg[23:16];
        3'd2:    cur_byte = c_reg[15:8];
        3'd3:    cur_byte = c_reg[7:0];
        default: cur_byte = {1'b0, flags_reg, crc};
      endcase
    end
  end

  // state names the bit that is on dout; dout_n is the bit for the next state
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    frame_n = frame_cnt;
    dout_n  = 1'b1;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (res_valid || err_valid) begin
          accept  = 1'b1;
          state_n = START;
          frame_n = '0;
          dout_n  = 1'b0;
        end
      end
      START: begin
        state_n = TYPE;
        dout_n  = last_frame;
      end
      TYPE: begin
        state_n = DATA;
        bit_n   = 3'd7;
        dout_n  = cur_byte[7];
      end
      DATA: begin
        if (bit_cnt == 3'd0) begin
          state_n = STOP;
        end else begin
          bit_n  = bit_cnt - 3'd1;
          dout_n = cur_byte[bit_cnt - 3'd1];
        end
      end
      STOP, GAP: begin
        if (state == STOP && GAP_BITS != 0) begin
          state_n = GAP;
          gap_n   = GAP_LOAD;
        end else if (state == GAP && gap_cnt != 3'd0) begin
          gap_n = gap_cnt - 3'd1;
        end else if (last_frame) begin
          state_n = IDLE;
        end else begin
          state_n = START;
          frame_n = frame_cnt + 3'd1;
          dout_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      is_err    <= 1'b0;
      c_reg     <= '0;
      flags_reg <= '0;
      err_reg   <= '0;
      dout      <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
      frame_cnt <= frame_n;
      dout      <= dout_n;
      busy      <= (state_n != IDLE);
      if (accept) begin
        is_err    <= err_valid;
        c_reg     <= C_in;
        flags_reg <= FLAGS_in;
        err_reg   <= err_frame_in;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: one instance without gaps, one with GAP_BITS=2.
module tb_mtm_alu_serializer;

  logic        clk;
  logic        rst;
  logic        res_valid0, err_valid0, res_valid1, err_valid1;
  logic [31:0] c_in;
  logic [3:0]  flags_in;
  logic [7:0]  err_in;
  logic        dout0, busy0, dout1, busy1;

  int checks = 0;
  int errors = 0;

  mtm_alu_serializer #(.GAP_BITS(0), .CRC_INIT(3'b000)) dut0 (
    .clk(clk), .rst(rst), .res_valid(res_valid0), .C_in(c_in), .FLAGS_in(flags_in),
    .err_valid(err_valid0), .err_frame_in(err_in), .dout(dout0), .busy(busy0)
  );

  mtm_alu_serializer #(.GAP_BITS(2), .CRC_INIT(3'b000)) dut1 (
    .clk(clk), .rst(rst), .res_valid(res_valid1), .C_in(c_in), .FLAGS_in(flags_in),
    .err_valid(err_valid1), .err_frame_in(err_in), .dout(dout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          g;
    bit          rv;
    bit          ev;
    logic [31:0] c;
    logic [3:0]  f;
    logic [7:0]  eb;
    logic [2:0]  crc;
    bit          use_model;
    int          pulse;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Long division of {msg, 000} by 1011
  function automatic logic [2:0] model_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  task automatic add_frame(input bit typ, input logic [7:0] b, input int gap,
                           inout logic [127:0] s, inout int n);
    logic [10:0] fr;
    fr = {1'b0, typ, b, 1'b1};
    for (int k = 10; k >= 0; k--) begin
      s = {s[126:0], fr[k]};
      n++;
    end
    for (int k = 0; k < gap; k++) begin
      s = {s[126:0], 1'b1};
      n++;
    end
  endtask

  task automatic set_valid(input bit g, input bit rv, input bit ev);
    if (g) begin res_valid1 = rv; err_valid1 = ev; end
    else   begin res_valid0 = rv; err_valid0 = ev; end
  endtask

  // Called at a negedge; the request is taken at the following posedge
  task automatic send(input vec_t v, output logic [127:0] s, output int n, output bit idle_dout);
    c_in = v.c; flags_in = v.f; err_in = v.eb;
    set_valid(v.g, v.rv, v.ev);
    @(negedge clk);
    set_valid(v.g, 1'b0, 1'b0);
    c_in = $urandom; flags_in = 4'($urandom); err_in = 8'($urandom);
    s = '0;
    n = 0;
    while (n < 200) begin
      if (!(v.g ? busy1 : busy0)) break;
      s = {s[126:0], (v.g ? dout1 : dout0)};
      n++;
      set_valid(v.g, (n == v.pulse), 1'b0);
      @(negedge clk);
    end
    set_valid(v.g, 1'b0, 1'b0);
    idle_dout = v.g ? dout1 : dout0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [127:0] exp_s, act_s;
    int           exp_n, act_n;
    bit           idle_dout;
    logic [2:0]   crc;
    int           gap;
    gap   = v.g ? 2 : 0;
    exp_s = '0;
    exp_n = 0;
    if (v.ev) begin
      add_frame(1'b1, v.eb, gap, exp_s, exp_n);
    end else begin
      crc = v.use_model ? model_crc(v.c, v.f) : v.crc;
      add_frame(1'b0, v.c[31:24], gap, exp_s, exp_n);
      add_frame(1'b0, v.c[23:16], gap, exp_s, exp_n);
      add_frame(1'b0, v.c[15:8],  gap, exp_s, exp_n);
      add_frame(1'b0, v.c[7:0],   gap, exp_s, exp_n);
      add_frame(1'b1, {1'b0, v.f, crc}, gap, exp_s, exp_n);
    end
    send(v, act_s, act_n, idle_dout);
    check({tag, "_stream"}, act_s, exp_s);
    check({tag, "_busy_len"}, 128'(act_n), 128'(exp_n));
    check({tag, "_idle_dout"}, 128'(idle_dout), 128'(1));
  endtask

  initial begin
    bit idle_ok;
    vecs[0] = '{0, 1, 0, 32'h0000_0000, 4'h0, 8'h00, 3'b000, 0, -1};
    vecs[1] = '{0, 1, 0, 32'hA5C3_0F81, 4'hA, 8'h00, 3'b000, 1, -1};
    vecs[2] = '{0, 0, 1, 32'h1234_5678, 4'h3, 8'hE0, 3'b000, 0,  3};
    vecs[3] = '{0, 1, 0, 32'h0000_0001, 4'h0, 8'h00, 3'b010, 0, -1};
    vecs[4] = '{0, 1, 0, 32'h0000_0000, 4'h8, 8'h00, 3'b101, 0, -1};
    vecs[5] = '{0, 1, 1, 32'hFFFF_FFFF, 4'hF, 8'h81, 3'b000, 0, -1};
    vecs[6] = '{1, 1, 0, 32'hA5C3_0F81, 4'h5, 8'h00, 3'b000, 1, -1};
    vecs[7] = '{1, 0, 1, 32'h0000_0000, 4'h0, 8'h3C, 3'b000, 0, -1};

    rst = 1'b0;
    res_valid0 = 0; err_valid0 = 0; res_valid1 = 0; err_valid1 = 0;
    c_in = '0; flags_in = '0; err_in = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      res_valid0 = 1'($urandom); err_valid0 = 1'($urandom);
      res_valid1 = 1'($urandom); err_valid1 = 1'($urandom);
      c_in = $urandom; flags_in = 4'($urandom); err_in = 8'($urandom);
    end
    @(negedge clk);
    check("reset_dout0", 128'(dout0), 128'(1));
    check("reset_busy0", 128'(busy0), 128'(0));
    check("reset_dout1", 128'(dout1), 128'(1));
    check("reset_busy1", 128'(busy1), 128'(0));
    res_valid0 = 0; err_valid0 = 0; res_valid1 = 0; err_valid1 = 0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].pulse >= 0) begin
        @(negedge clk);
        check($sformatf("vec%0d_pulse_ignored", i), 128'(busy0), 128'(0));
      end
    end

    // Reset in the middle of a result, on a data bit that is low
    c_in = '0; flags_in = '0; res_valid0 = 1'b1;
    @(negedge clk);
    res_valid0 = 1'b0;
    repeat (4) @(negedge clk);
    check("midframe_dout_low", 128'(dout0), 128'(0));
    rst = 1'b0;
    #1;
    check("midframe_reset_dout", 128'(dout0), 128'(1));
    check("midframe_reset_busy", 128'(busy0), 128'(0));
    #3 rst = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || dout0 !== 1'b1) idle_ok = 1'b0;
    end
    check("after_reset_idle", 128'(idle_ok), 128'(1));

    run_vec(vecs[1], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
